// File: rtl/quadrature_encoder_emulator.sv
// Quadrature A/B generator with programmable step interval and direction,
// running continuously or for a counted burst, and tracking emitted position.
module quadrature_encoder_emulator #(
  parameter int PERIOD_WIDTH = 16,
  parameter int COUNT_WIDTH  = 32,
  parameter int BURST_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    direction,
  input  logic [PERIOD_WIDTH-1:0] tick_period,
  input  logic                    burst_start,
  input  logic [BURST_WIDTH-1:0]  burst_ticks,
  output logic                    burst_busy,
  output logic                    burst_done,
  output logic                    sig_a,
  output logic                    sig_b,
  output logic                    state_change,
  output logic [COUNT_WIDTH-1:0]  tick_count,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [PERIOD_WIDTH-1:0] period_cnt, period_cnt_n;
  logic [PERIOD_WIDTH-1:0] latched_period, latched_period_n;
  logic                    latched_dir, latched_dir_n;
  logic [BURST_WIDTH-1:0]  remaining, remaining_n;
  logic                    sig_a_n, sig_b_n, state_change_n;
  logic                    burst_busy_n, burst_done_n;
  logic [COUNT_WIDTH-1:0]  tick_count_n;
  logic                    step;

  assign state_dbg = state;

  // Burst request: burst_start is a one-cycle strobe honoured only in IDLE;
  // burst_busy marks acceptance and burst_done closes the transaction.
  always_comb begin
    state_n          = state;
    period_cnt_n     = period_cnt;
    latched_period_n = latched_period;
    latched_dir_n    = latched_dir;
    remaining_n      = remaining;
    sig_a_n          = sig_a;
    sig_b_n          = sig_b;
    tick_count_n     = tick_count;
    state_change_n   = 1'b0;
    burst_busy_n     = burst_busy;
    burst_done_n     = 1'b0;
    step             = 1'b0;

    case (state)
      ST_IDLE: begin
        if (burst_start) begin
          state_n          = ST_BURST;
          remaining_n      = burst_ticks;
          latched_period_n = tick_period;
          latched_dir_n    = direction;
          period_cnt_n     = '0;
          burst_busy_n     = 1'b1;
        end else if (enable) begin
          state_n          = ST_RUN;
          latched_period_n = tick_period;
          latched_dir_n    = direction;
          period_cnt_n     = '0;
        end
      end
      ST_RUN, ST_BURST: begin
        if (state == ST_BURST && remaining == '0) begin
          state_n      = ST_IDLE;
          burst_done_n = 1'b1;
          burst_busy_n = 1'b0;
        end else if (latched_period == '0) begin
          // Stalled: keep polling the period; timing restarts from the edge it turns nonzero.
          latched_period_n = tick_period;
          latched_dir_n    = direction;
          period_cnt_n     = '0;
        end else if (period_cnt == latched_period - 1'b1) begin
          step             = 1'b1;
          period_cnt_n     = '0;
          latched_period_n = tick_period;
          latched_dir_n    = direction;
          if (state == ST_BURST) begin
            remaining_n = remaining - 1'b1;
            if (remaining == BURST_WIDTH'(1)) begin
              state_n      = ST_IDLE;
              burst_done_n = 1'b1;
              burst_busy_n = 1'b0;
            end
          end
        end else begin
          period_cnt_n = period_cnt + 1'b1;
        end
        if (state == ST_RUN && !enable) begin
          state_n      = ST_IDLE;
          period_cnt_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (step) begin
      state_change_n = 1'b1;
      if (latched_dir) begin
        sig_a_n      = ~sig_b;
        sig_b_n      = sig_a;
        tick_count_n = tick_count + COUNT_WIDTH'(1);
      end else begin
        sig_a_n      = sig_b;
        sig_b_n      = ~sig_a;
        tick_count_n = tick_count - COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      period_cnt     <= '0;
      latched_period <= '0;
      latched_dir    <= 1'b0;
      remaining      <= '0;
      sig_a          <= 1'b0;
      sig_b          <= 1'b0;
      tick_count     <= '0;
      state_change   <= 1'b0;
      burst_busy     <= 1'b0;
      burst_done     <= 1'b0;
    end else begin
      state          <= state_n;
      period_cnt     <= period_cnt_n;
      latched_period <= latched_period_n;
      latched_dir    <= latched_dir_n;
      remaining      <= remaining_n;
      sig_a          <= sig_a_n;
      sig_b          <= sig_b_n;
      tick_count     <= tick_count_n;
      state_change   <= state_change_n;
      burst_busy     <= burst_busy_n;
      burst_done     <= burst_done_n;
    end
  end

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Directed bench for quadrature_encoder_emulator: expected A/B events are
// queued with their cycle of arrival and checked by a monitor thread.
module tb_quadrature_encoder_emulator;

  localparam int W = 68;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        direction = 1'b0;
  logic [15:0] tick_period = '0;
  logic        burst_start = 1'b0;
  logic [15:0] burst_ticks = '0;
  logic        burst_busy, burst_done, sig_a, sig_b, state_change;
  logic [31:0] tick_count;
  logic [1:0]  state_dbg;

  logic [31:0] cyc = '0;
  logic [W-1:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int busy_total = 0;

  int ph = 0;
  logic [31:0] mcnt = '0;
  logic [1:0] ab_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quadrature_encoder_emulator dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .direction    (direction),
    .tick_period  (tick_period),
    .burst_start  (burst_start),
    .burst_ticks  (burst_ticks),
    .burst_busy   (burst_busy),
    .burst_done   (burst_done),
    .sig_a        (sig_a),
    .sig_b        (sig_b),
    .state_change (state_change),
    .tick_count   (tick_count),
    .state_dbg    (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue n expected steps, the k-th landing on edge entry + k*p.
  task automatic push_steps(input int entry, input int p, input int n, input bit dir, input bit burst_end);
    logic done_bit;
    for (int k = 1; k <= n; k++) begin
      if (dir) begin
        ph = (ph + 1) % 4;
        mcnt = mcnt + 32'd1;
      end else begin
        ph = (ph + 3) % 4;
        mcnt = mcnt - 32'd1;
      end
      done_bit = burst_end && (k == n);
      exp_q.push_back({32'(entry + k * p), 1'b1, done_bit, ab_seq[ph], mcnt});
    end
  endtask

  task automatic monitor_loop();
    logic [W-1:0] act;
    forever begin
      @(negedge clk);
      if (burst_busy) busy_total++;
      if (state_change || burst_done) begin
        act = {cyc, state_change, burst_done, sig_a, sig_b, tick_count};
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL spurious_event: got %h expected no event", act);
        end else begin
          check("event", act, exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    enable = 1'b0;
    burst_start = 1'b0;
    tick(2);
    reset = 1'b0;
    ph = 0;
    mcnt = '0;
  endtask

  // Called at a negedge; request is sampled on the next edge (the entry edge).
  task automatic start_burst(input int ticks, input bit dir, input int p, output int entry);
    burst_ticks = 16'(ticks);
    direction = dir;
    tick_period = 16'(p);
    burst_start = 1'b1;
    entry = int'(cyc) + 1;
    tick(1);
    burst_start = 1'b0;
  endtask

  initial begin
    int entry, b0;
    fork
      monitor_loop();
    join_none

    // reset values
    tick(3);
    check("rst_ab", 68'({sig_a, sig_b}), 68'(2'b00));
    check("rst_count", 68'(tick_count), 68'(32'd0));
    check("rst_flags", 68'({state_change, burst_busy, burst_done}), 68'(3'b000));
    check("rst_state", 68'(state_dbg), 68'(2'd0));
    reset = 1'b0;
    tick(1);

    // continuous forward run, P=3, 40 clocks
    enable = 1'b1; direction = 1'b1; tick_period = 16'd3;
    entry = int'(cyc) + 1;
    push_steps(entry, 3, 13, 1'b1, 1'b0);
    tick(5);
    check("run_state", 68'(state_dbg), 68'(2'd1));
    tick(34);
    enable = 1'b0;
    tick(6);
    check("run_count", 68'(tick_count), 68'(32'd13));
    check("run_ab", 68'({sig_a, sig_b}), 68'(2'b10));

    // stalled period, then P=5
    reset_dut();
    enable = 1'b1; direction = 1'b1; tick_period = 16'd0;
    tick(20);
    tick_period = 16'd5;
    push_steps(int'(cyc) + 1, 5, 1, 1'b1, 1'b0);
    tick(8);
    enable = 1'b0;
    tick(6);
    check("stall_count", 68'(tick_count), 68'(32'd1));

    // reverse burst of 7 at P=2
    reset_dut();
    b0 = busy_total;
    start_burst(7, 1'b0, 2, entry);
    push_steps(entry, 2, 7, 1'b0, 1'b1);
    tick(3);
    check("burst_state", 68'(state_dbg), 68'(2'd2));
    tick(17);
    check("burst_count", 68'(tick_count), 68'(32'hFFFF_FFF9));
    check("burst_ab", 68'({sig_a, sig_b}), 68'(2'b10));
    check("burst_busy_len", 68'(busy_total - b0), 68'(14));

    // zero-length burst, then 4-tick burst with an ignored second request
    reset_dut();
    b0 = busy_total;
    start_burst(0, 1'b1, 1, entry);
    exp_q.push_back({32'(entry + 1), 1'b0, 1'b1, 2'b00, 32'd0});
    tick(1);
    check("zero_busy_len", 68'(busy_total - b0), 68'(1));
    start_burst(4, 1'b1, 1, entry);
    push_steps(entry, 1, 4, 1'b1, 1'b1);
    burst_ticks = 16'd10;
    burst_start = 1'b1;
    tick(1);
    burst_start = 1'b0;
    tick(10);
    check("ignored_start_count", 68'(tick_count), 68'(32'd4));
    check("ignored_start_idle", 68'({burst_busy, state_dbg}), 68'(3'b000));

    // direction flip mid-interval, P=4
    reset_dut();
    enable = 1'b1; direction = 1'b1; tick_period = 16'd4;
    entry = int'(cyc) + 1;
    push_steps(entry, 4, 2, 1'b1, 1'b0);
    push_steps(entry + 8, 4, 1, 1'b0, 1'b0);
    tick(6);
    direction = 1'b0;
    tick(6);
    enable = 1'b0;
    tick(6);
    check("flip_ab", 68'({sig_a, sig_b}), 68'(2'b10));
    check("flip_count", 68'(tick_count), 68'(32'd1));

    // reset during burst step 3 of 10, then a full burst
    reset_dut();
    start_burst(10, 1'b1, 2, entry);
    push_steps(entry, 2, 3, 1'b1, 1'b0);
    tick(6);
    reset = 1'b1;
    tick(1);
    check("midrst_ab_count", 68'({sig_a, sig_b, tick_count}), 68'(34'd0));
    check("midrst_flags", 68'({state_change, burst_busy, burst_done, state_dbg}), 68'(5'd0));
    tick(1);
    reset = 1'b0;
    ph = 0;
    mcnt = '0;
    b0 = busy_total;
    start_burst(10, 1'b1, 1, entry);
    push_steps(entry, 1, 10, 1'b1, 1'b1);
    tick(16);
    check("postrst_count", 68'(tick_count), 68'(32'd10));
    check("postrst_ab", 68'({sig_a, sig_b}), 68'(2'b11));
    check("postrst_busy_len", 68'(busy_total - b0), 68'(10));

    tick(4);
    check("queue_drained", 68'(exp_q.size()), 68'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
